// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_resp_pkg;
  localparam int          CNT_W     = 4;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_RW} op_t;

  function automatic op_t decode_op(input logic rd, input logic wr);
    return (rd && wr) ? OP_RW : (wr ? OP_WR : OP_RD);
  endfunction

  function automatic logic op_reads(input op_t op);
    return op != OP_WR;
  endfunction

  function automatic logic op_writes(input op_t op);
    return op != OP_RD;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus. err exists only when DMEM_RESP_ALIGN_CHK_EN is defined.
interface dmem_responder_if;
  logic        RRam;
  logic        WRam;
  logic [31:0] daddr;
  logic [31:0] ddata_w;
  logic [31:0] ddata_r;
  logic        done;
  logic        busy;
`ifdef DMEM_RESP_ALIGN_CHK_EN
  logic        err;
  modport master (output RRam, WRam, daddr, ddata_w, input ddata_r, done, busy, err);
  modport slave  (input RRam, WRam, daddr, ddata_w, output ddata_r, done, busy, err);
`else
  modport master (output RRam, WRam, daddr, ddata_w, input ddata_r, done, busy);
  modport slave  (input RRam, WRam, daddr, ddata_w, output ddata_r, done, busy);
`endif
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM, registered read (read-before-write on a shared address).
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency target for the core's RRam/WRam data handshake, backed by dmem_array.
// Optional DMEM_RESP_ALIGN_CHK_EN: flags misaligned accesses on err and suppresses them.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic             CLK,
  input  logic             RST,
  dmem_responder_if.slave  bus
);
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t             state;
  op_t                op_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt;
  logic               done_q, busy_q;
  logic [31:0]        rd_hold;
  logic [ADDR_W-1:0]  ram_addr;
  logic [31:0]        ram_rdata, resp_rdata;
  logic               ram_we, mis;
  logic               req;
  logic               unused_addr;

  assign req         = bus.RRam | bus.WRam;
  assign unused_addr = ^{bus.daddr[31:ADDR_W+2], bus.daddr[1:0]};

`ifdef DMEM_RESP_ALIGN_CHK_EN
  logic [1:0] lo_q;
  logic       err_q;
  assign mis     = |lo_q;
  assign bus.err = err_q;
`else
  assign mis = 1'b0;
`endif

  // In IDLE the RAM reads the live address so the word is ready even when LATENCY==1.
  assign ram_addr   = (state == IDLE) ? bus.daddr[ADDR_W+1:2] : idx_q;
  assign ram_we     = (state == RESP) && !RST && op_writes(op_q) && !mis;
  assign resp_rdata = (mis && op_reads(op_q)) ? ERR_RDATA : ram_rdata;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rd_hold <= '0;
`ifdef DMEM_RESP_ALIGN_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req) begin
          op_q    <= decode_op(bus.RRam, bus.WRam);
          idx_q   <= bus.daddr[ADDR_W+1:2];
          wdata_q <= bus.ddata_w;
          busy_q  <= 1'b1;
          cnt     <= CNT_INIT;
`ifdef DMEM_RESP_ALIGN_CHK_EN
          lo_q    <= bus.daddr[1:0];
          err_q   <= (LATENCY == 1) && (|bus.daddr[1:0]);
`endif
          if (LATENCY == 1) begin
            state  <= RESP;
            done_q <= 1'b1;
          end else begin
            state  <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state  <= RESP;
            done_q <= 1'b1;
`ifdef DMEM_RESP_ALIGN_CHK_EN
            err_q  <= mis;
`endif
          end
        end
        RESP: begin
          state   <= DRAIN;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          rd_hold <= resp_rdata;
`ifdef DMEM_RESP_ALIGN_CHK_EN
          err_q   <= 1'b0;
`endif
        end
        // A strobe still held after done must not start a second transaction.
        DRAIN: if (!req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.ddata_r = (state == RESP) ? resp_rdata : rd_hold;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against a
// timestamp-based transaction model checked every cycle.
module tb_dmem_responder;
  localparam int ADDR_W = 10;
  localparam int LAT    = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dmem_responder_if bus();
  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_FREE, M_BUSY, M_DRAIN} mphase_t;
  mphase_t     ph = M_FREE;
  longint      cyc = 0;
  longint      done_at = -10;
  logic [31:0] mem [int];
  int          m_idx;
  logic        m_rd, m_wr;
  logic [31:0] m_wd;
  logic [1:0]  m_lo;
  logic [31:0] hold;
  bit          hold_known = 1'b0;
  bit          started = 1'b0;
  bit          e_done;
  logic [31:0] e_data;

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  function automatic bit m_misal();
`ifdef DMEM_RESP_ALIGN_CHK_EN
    return m_lo != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      ph = M_FREE; hold = '0; hold_known = 1'b1; started = 1'b1;
    end else begin
      case (ph)
        M_FREE: if (bus.RRam || bus.WRam) begin
          m_rd = bus.RRam; m_wr = bus.WRam; m_idx = widx(bus.daddr);
          m_wd = bus.ddata_w; m_lo = bus.daddr[1:0];
          done_at = cyc + LAT - 1;
          ph = M_BUSY;
        end
        M_BUSY: if (cyc == done_at + 1) begin
          if (m_wr && !m_misal()) mem[m_idx] = m_wd;
          ph = M_DRAIN;
        end
        M_DRAIN: if (!bus.RRam && !bus.WRam) ph = M_FREE;
        default: ph = M_FREE;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      e_done = (ph == M_BUSY) && (cyc == done_at);
      chk("done", {31'b0, bus.done}, {31'b0, e_done});
      chk("busy", {31'b0, bus.busy}, {31'b0, ph == M_BUSY});
`ifdef DMEM_RESP_ALIGN_CHK_EN
      chk("err", {31'b0, bus.err}, {31'b0, e_done && m_misal()});
`endif
      if (e_done) begin
        if (m_misal() && m_rd) begin
          hold = 32'hDEAD_BEEF; hold_known = 1'b1;
        end else if (mem.exists(m_idx)) begin
          e_data = mem[m_idx]; hold = e_data; hold_known = 1'b1;
        end else begin
          hold_known = 1'b0;
        end
      end
      if (hold_known) chk("ddata_r", bus.ddata_r, hold);
    end
  end

  // ---------------- requester ----------------
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input int extra, output logic [31:0] rdata, output int lat, output int pulses);
    @(negedge CLK);
    bus.RRam = rd; bus.WRam = wr; bus.daddr = a; bus.ddata_w = wd;
    lat = 0; pulses = 0; rdata = 'x;
    do begin
      @(negedge CLK);
      lat++;
      // captured values must win over anything presented after accept
      if (lat == 1) begin bus.daddr = $urandom; bus.ddata_w = $urandom; end
    end while (!bus.done && lat < 40);
    if (!bus.done) begin
      vectors++; miscompares++;
      $display("FAIL txn_timeout: no done within %0d cycles for addr %h", lat, a);
    end else begin
      pulses = 1;
      rdata = bus.ddata_r;
    end
    repeat (extra) begin
      @(negedge CLK);
      if (bus.done) pulses++;
    end
    bus.RRam = 1'b0; bus.WRam = 1'b0;
    @(negedge CLK);
  endtask

  task automatic abort_wr(input logic [31:0] a, input logic [31:0] wd);
    @(negedge CLK);
    bus.WRam = 1'b1; bus.daddr = a; bus.ddata_w = wd;
    @(negedge CLK);
    RST = 1'b1; bus.WRam = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, a;
    int lat, p, idx;
    RST = 1'b1; bus.RRam = 1'b0; bus.WRam = 1'b0; bus.daddr = '0; bus.ddata_w = '0;
    repeat (3) @(negedge CLK);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_ddata_r", bus.ddata_r, 32'd0);
    RST = 1'b0;

    txn(1'b0, 1'b1, 32'h10, 32'hCAFE_0001, 0, r, lat, p);
    chk("t1_wr_lat", lat, LAT);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 0, r, lat, p);
    chk("t1_rd_lat", lat, LAT);
    chk("t1_rd_data", r, 32'hCAFE_0001);

    txn(1'b1, 1'b0, 32'h10, 32'h0, 3, r, lat, p);
    chk("t2_held_pulses", p, 1);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 0, r, lat, p);
    chk("t2_second_pulse", p, 1);
    chk("t2_second_data", r, 32'hCAFE_0001);

    txn(1'b0, 1'b1, 32'h14, 32'h1111, 0, r, lat, p);
    txn(1'b1, 1'b1, 32'h14, 32'h2222, 0, r, lat, p);
    chk("t3_rw_old", r, 32'h1111);
    chk("t3_rw_pulses", p, 1);
    txn(1'b1, 1'b0, 32'h14, 32'h0, 0, r, lat, p);
    chk("t3_rd_new", r, 32'h2222);

    txn(1'b0, 1'b1, 32'h20, 32'h3333, 0, r, lat, p);
    abort_wr(32'h20, 32'h4444);
    txn(1'b1, 1'b0, 32'h20, 32'h0, 0, r, lat, p);
    chk("t4_rd_old", r, 32'h3333);

    txn(1'b0, 1'b1, 32'h1004, 32'hA5A5_A5A5, 0, r, lat, p);
    txn(1'b1, 1'b0, 32'h0004, 32'h0, 0, r, lat, p);
    chk("t5_alias", r, 32'hA5A5_A5A5);

`ifdef DMEM_RESP_ALIGN_CHK_EN
    txn(1'b0, 1'b1, 32'h10, 32'h7777, 0, r, lat, p);
    txn(1'b1, 1'b0, 32'h13, 32'h0, 0, r, lat, p);
    chk("t6_misal_rd", r, 32'hDEAD_BEEF);
    txn(1'b0, 1'b1, 32'h13, 32'h9999, 0, r, lat, p);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 0, r, lat, p);
    chk("t6_misal_wr_nochange", r, 32'h7777);
`endif

    for (int i = 0; i < 16; i++)
      txn(1'b0, 1'b1, 32'(i) << 2, $urandom, 0, r, lat, p);

    for (int i = 0; i < 300; i++) begin
      idx = $urandom_range(0, 15);
      a = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        abort_wr(a, $urandom);
      end else begin
        case ($urandom_range(0, 2))
          0: txn(1'b1, 1'b0, a, $urandom, $urandom_range(0, 3), r, lat, p);
          1: txn(1'b0, 1'b1, a, $urandom, $urandom_range(0, 3), r, lat, p);
          default: txn(1'b1, 1'b1, a, $urandom, $urandom_range(0, 3), r, lat, p);
        endcase
      end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    repeat (4) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
